// File: rtl/pattern_match_detector.sv
// Masked pattern detector: pulses once when RUN_LEN consecutive valid words match, with a saturating match counter.
// The counter and overflow logic are built only when PATTERN_MATCH_COUNT_EN is defined.
module pattern_match_detector #(
    parameter int WIDTH   = 4,
    parameter int RUN_LEN = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_pattern,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             count_clr,
    output logic             match,
    output logic             run_active,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow
);

    localparam int RC_W = $clog2(RUN_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_MATCHED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [RC_W-1:0]   r_run_cnt;
    logic [RC_W-1:0]   w_run_cnt_nxt;
    logic [RC_W-1:0]   w_run_inc;
    logic [WIDTH-1:0]  r_pattern;
    logic [WIDTH-1:0]  r_mask;
    logic              r_match;
    logic              w_hit;
    logic              w_pulse;

    assign w_hit     = ((in_data ^ r_pattern) & r_mask) == '0;
    assign w_run_inc = r_run_cnt + RC_W'(1);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_run_cnt_nxt = r_run_cnt;
        w_pulse       = 1'b0;
        if (cfg_load) begin
            w_state_nxt   = S_IDLE;
            w_run_cnt_nxt = '0;
        end else if (in_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        if (RUN_LEN == 1) begin
                            w_state_nxt = S_MATCHED;
                            w_pulse     = 1'b1;
                        end else begin
                            w_state_nxt   = S_RUN;
                            w_run_cnt_nxt = RC_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (!w_hit) begin
                        w_state_nxt   = S_IDLE;
                        w_run_cnt_nxt = '0;
                    end else if (w_run_inc == RC_W'(RUN_LEN)) begin
                        w_state_nxt   = S_MATCHED;
                        w_run_cnt_nxt = '0;
                        w_pulse       = 1'b1;
                    end else begin
                        w_run_cnt_nxt = w_run_inc;
                    end
                end
                S_MATCHED: begin
                    // Non-overlapping: only a miss re-arms detection.
                    if (!w_hit) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_run_cnt_nxt = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_run_cnt <= '0;
            r_pattern <= ~WIDTH'(1);
            r_mask    <= '1;
            r_match   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_cnt_nxt;
            r_match   <= w_pulse;
            if (cfg_load) begin
                r_pattern <= cfg_pattern;
                r_mask    <= cfg_mask;
            end
        end
    end

    assign match      = r_match;
    assign run_active = (r_state != S_IDLE);

`ifdef PATTERN_MATCH_COUNT_EN
    logic [CNT_W-1:0] r_match_count;
    logic             r_overflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_match_count <= '0;
            r_overflow    <= 1'b0;
        end else if (count_clr) begin
            r_match_count <= w_pulse ? CNT_W'(1) : '0;
            r_overflow    <= 1'b0;
        end else if (w_pulse) begin
            if (r_match_count == '1) begin
                r_overflow <= 1'b1;
            end else begin
                r_match_count <= r_match_count + CNT_W'(1);
            end
        end
    end

    assign match_count = r_match_count;
    assign overflow    = r_overflow;
`else
    logic w_unused_count_clr;

    assign w_unused_count_clr = count_clr;
    assign match_count        = {CNT_W{1'b0}};
    assign overflow           = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_match_detector.sv
// Randomized bench for pattern_match_detector: three instances (RUN_LEN 1/3/2) share stimulus and are
// compared each cycle against a consecutive-hit streak model.
module tb_pattern_match_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic [3:0] cfg_mask;
    logic       in_valid;
    logic [3:0] in_data;
    logic       count_clr;

    logic       match_o [3];
    logic       run_o   [3];
    logic       ovf_o   [3];
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [2:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: streak = consecutive hits since last miss/reload/reset.
    localparam int RL   [3] = '{1, 3, 2};
    localparam int CMAX [3] = '{255, 3, 7};
    logic [3:0] m_pat;
    logic [3:0] m_msk;
    int         streak [3];
    int         m_cnt  [3];
    bit         m_ovf  [3];
    bit         m_pls  [3];

    always #5 clk = ~clk;

    pattern_match_detector #(.WIDTH(4), .RUN_LEN(1), .CNT_W(8)) u_d0 (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask), .in_valid(in_valid), .in_data(in_data), .count_clr(count_clr),
        .match(match_o[0]), .run_active(run_o[0]), .match_count(cnt0), .overflow(ovf_o[0]));

    pattern_match_detector #(.WIDTH(4), .RUN_LEN(3), .CNT_W(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask), .in_valid(in_valid), .in_data(in_data), .count_clr(count_clr),
        .match(match_o[1]), .run_active(run_o[1]), .match_count(cnt1), .overflow(ovf_o[1]));

    pattern_match_detector #(.WIDTH(4), .RUN_LEN(2), .CNT_W(3)) u_d2 (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask), .in_valid(in_valid), .in_data(in_data), .count_clr(count_clr),
        .match(match_o[2]), .run_active(run_o[2]), .match_count(cnt2), .overflow(ovf_o[2]));

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        bit hit;
        if (!rst_n) begin
            m_pat = 4'b1110;
            m_msk = 4'b1111;
            for (int k = 0; k < 3; k++) begin
                streak[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_pls[k] = 0;
            end
        end else begin
            hit = ((in_data ^ m_pat) & m_msk) == 4'b0000;
            for (int k = 0; k < 3; k++) begin
                m_pls[k] = 0;
                if (cfg_load) begin
                    streak[k] = 0;
                end else if (in_valid) begin
                    if (hit) begin
                        if (streak[k] < 1000) streak[k]++;
                        m_pls[k] = (streak[k] == RL[k]);
                    end else begin
                        streak[k] = 0;
                    end
                end
                if (count_clr) begin
                    m_cnt[k] = m_pls[k] ? 1 : 0;
                    m_ovf[k] = 0;
                end else if (m_pls[k]) begin
                    if (m_cnt[k] == CMAX[k]) m_ovf[k] = 1;
                    else m_cnt[k]++;
                end
            end
            if (cfg_load) begin
                m_pat = cfg_pattern;
                m_msk = cfg_mask;
            end
        end
    endtask

    task automatic compare_all();
        int got_cnt [3];
        got_cnt[0] = int'(cnt0);
        got_cnt[1] = int'(cnt1);
        got_cnt[2] = int'(cnt2);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("match[%0d]", k), match_o[k], m_pls[k]);
            check($sformatf("run_active[%0d]", k), run_o[k], streak[k] > 0);
`ifdef PATTERN_MATCH_COUNT_EN
            check($sformatf("match_count[%0d]", k), got_cnt[k], m_cnt[k]);
            check($sformatf("overflow[%0d]", k), ovf_o[k], m_ovf[k]);
`else
            check($sformatf("match_count[%0d]", k), got_cnt[k], 0);
            check($sformatf("overflow[%0d]", k), ovf_o[k], 0);
`endif
        end
    endtask

    task automatic step(input logic rst, input logic cfg, input logic [3:0] pat, input logic [3:0] msk,
                        input logic v, input logic [3:0] d, input logic clr);
        rst_n = rst; cfg_load = cfg; cfg_pattern = pat; cfg_mask = msk;
        in_valid = v; in_data = d; count_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic word(input logic v, input logic [3:0] d);
        step(1'b1, 1'b0, 4'h0, 4'h0, v, d, 1'b0);
    endtask

    initial begin
        logic [3:0] d;
        rst_n = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_mask = '0;
        in_valid = 1'b0; in_data = '0; count_clr = 1'b0;
        m_pat = 4'b1110; m_msk = 4'b1111;

        // Reset defaults.
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'he, 1'b1);
        check("reset_match", match_o[0], 0);
        check("reset_run_active", run_o[1], 0);

        // Default pattern 1110: hit then miss.
        word(1'b1, 4'b1110);
        check("default_pulse", match_o[0], 1);
        word(1'b1, 4'b0110);
        check("default_no_repeat", match_o[0], 0);

        // Masked reload, then repeated hits and a miss.
        step(1'b1, 1'b1, 4'b0001, 4'b0011, 1'b1, 4'b0001, 1'b0);
        word(1'b1, 4'b1101);
        word(1'b1, 4'b1001);
        word(1'b1, 4'b1100);
        word(1'b1, 4'b0101);

        // Back to default pattern; stalls inside a run.
        step(1'b1, 1'b1, 4'b1110, 4'b1111, 1'b0, 4'h0, 1'b0);
        word(1'b1, 4'b1110);
        word(1'b0, 4'b0000);
        word(1'b1, 4'b1110);
        word(1'b0, 4'b1110);
        word(1'b0, 4'b0000);
        word(1'b1, 4'b1110);
        check("stall_run3_pulse", match_o[1], 1);
        word(1'b1, 4'b0000);

        // Broken run.
        word(1'b1, 4'b1110);
        word(1'b1, 4'b1110);
        word(1'b1, 4'b0010);
        word(1'b1, 4'b1110);
        word(1'b1, 4'b1110);
        word(1'b1, 4'b1110);
        word(1'b1, 4'b0000);

        // Saturation on the 2-bit counter, then clear coinciding with a pulse.
        for (int i = 0; i < 5; i++) begin
            word(1'b1, 4'b1110);
            word(1'b1, 4'b1110);
            word(1'b1, 4'b1110);
            word(1'b1, 4'b0000);
        end
        word(1'b1, 4'b1110);
        word(1'b1, 4'b1110);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'b1110, 1'b1);
        word(1'b1, 4'b0000);

        // Mid-run reset with a completing hit.
        word(1'b1, 4'b1110);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'b1110, 1'b0);
        check("midrun_reset_match", match_o[2], 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(1)) d = (m_pat & m_msk) | (4'($urandom) & ~m_msk);
            else d = 4'($urandom);
            step(($urandom_range(299) != 0),
                 ($urandom_range(39) == 0),
                 4'($urandom),
                 ($urandom_range(3) == 0) ? 4'($urandom) : 4'b1111,
                 ($urandom_range(4) != 0),
                 d,
                 ($urandom_range(99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
